// File: rtl/ex_mem_skid_stage.sv
// EX->MEM pipeline stage with valid/ready handshake, 2-entry skid buffer,
// flush, bubble write-enable gating and a saturating back-pressure counter.
//
// state    | meaning
// ---------+-------------------------------------------------
// ST_EMPTY | no entry held; outputs invalid, in_ready=1
// ST_ONE   | main entry valid, skid empty; in_ready=1
// ST_FULL  | main and skid valid; in_ready=0
module ex_mem_skid_stage #(
  parameter int DATA_W = 32,
  parameter int OPC_W  = 6,
  parameter int RD_W   = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] reg_rs1_in,
  input  logic [DATA_W-1:0] alu_out_in,
  input  logic [DATA_W-1:0] immediate_value_in,
  input  logic [OPC_W-1:0]  opcode_in,
  input  logic [RD_W-1:0]   rd_in,
  input  logic              register_we_in,
  input  logic              data_we_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] reg_rs1_out,
  output logic [DATA_W-1:0] alu_out_out,
  output logic [DATA_W-1:0] immediate_value_out,
  output logic [OPC_W-1:0]  opcode_out,
  output logic [RD_W-1:0]   rd_out,
  output logic              register_we_out,
  output logic              data_we_out,
  output logic [CNT_W-1:0]  stall_count
);

  localparam int PAY_W = 3 * DATA_W + OPC_W + RD_W + 2;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PAY_W-1:0] main_q, skid_q, pay_in;
  logic [CNT_W-1:0] cnt_q;
  logic             load_main_in, load_main_skid, load_skid;
  logic             accept, emit, stall;
  logic             main_rwe, main_dwe;

  assign pay_in = {reg_rs1_in, alu_out_in, immediate_value_in, opcode_in, rd_in,
                   register_we_in, data_we_in};

  // Both handshake outputs decode flop state only; no path from out_ready.
  assign out_valid = (state_q != ST_EMPTY);
  assign in_ready  = (state_q != ST_FULL);
  assign accept    = in_valid & in_ready;
  assign emit      = out_valid & out_ready;
  assign stall     = out_valid & ~out_ready;

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            load_main_in = 1'b1;
            state_d      = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && emit) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            load_skid = 1'b1;
            state_d   = ST_FULL;
          end else if (emit) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (emit) begin
            load_main_skid = 1'b1;
            state_d        = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (load_main_in) begin
        main_q <= pay_in;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= pay_in;
      end
      // Flush deliberately does not touch the debug counter.
      if (stall && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign {reg_rs1_out, alu_out_out, immediate_value_out, opcode_out, rd_out,
          main_rwe, main_dwe} = main_q;

  assign register_we_out = main_rwe & out_valid;
  assign data_we_out     = main_dwe & out_valid;
  assign stall_count     = cnt_q;

endmodule

// File: tb/tb_ex_mem_skid_stage.sv
// Bench for ex_mem_skid_stage: directed vector table, a counter saturation
// sequence, and random traffic against a queue-based reference model.
module tb_ex_mem_skid_stage;

  typedef struct packed {
    logic [31:0] rs1;
    logic [31:0] alu;
    logic [31:0] imm;
    logic [5:0]  opc;
    logic [4:0]  rd;
    logic        rwe;
    logic        dwe;
  } pay_t;

  typedef struct {
    logic        rst, fl, iv, ordy;
    logic [31:0] alu;
    logic        rwe, dwe;
    logic        e_ov, e_ir;
    logic [31:0] e_alu;
    logic        e_rwe, e_dwe;
    logic [3:0]  e_st;
  } vec_t;

  logic        clock, reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] reg_rs1_in, alu_out_in, immediate_value_in;
  logic [31:0] reg_rs1_out, alu_out_out, immediate_value_out;
  logic [5:0]  opcode_in, opcode_out;
  logic [4:0]  rd_in, rd_out;
  logic        register_we_in, data_we_in, register_we_out, data_we_out;
  logic [3:0]  stall_count;

  int nvec = 0;
  int nerr = 0;

  ex_mem_skid_stage #(.DATA_W(32), .OPC_W(6), .RD_W(5), .CNT_W(4)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .reg_rs1_in(reg_rs1_in), .alu_out_in(alu_out_in),
    .immediate_value_in(immediate_value_in), .opcode_in(opcode_in), .rd_in(rd_in),
    .register_we_in(register_we_in), .data_we_in(data_we_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .reg_rs1_out(reg_rs1_out), .alu_out_out(alu_out_out),
    .immediate_value_out(immediate_value_out), .opcode_out(opcode_out),
    .rd_out(rd_out), .register_we_out(register_we_out), .data_we_out(data_we_out),
    .stall_count(stall_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic pay_t mkpay(input logic [31:0] alu, input logic rwe, input logic dwe);
    pay_t p;
    p.rs1 = alu ^ 32'hA5A5_0000;
    p.alu = alu;
    p.imm = ~alu;
    p.opc = alu[5:0] ^ 6'h2A;
    p.rd  = alu[4:0] + 5'd1;
    p.rwe = rwe;
    p.dwe = dwe;
    return p;
  endfunction

  task automatic drive(input logic rst, input logic fl, input logic iv, input logic ordy,
                       input pay_t p);
    reset              = rst;
    flush              = fl;
    in_valid           = iv;
    out_ready          = ordy;
    reg_rs1_in         = p.rs1;
    alu_out_in         = p.alu;
    immediate_value_in = p.imm;
    opcode_in          = p.opc;
    rd_in              = p.rd;
    register_we_in     = p.rwe;
    data_we_in         = p.dwe;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic pay_t dut_pay();
    pay_t p;
    p = {reg_rs1_out, alu_out_out, immediate_value_out, opcode_out, rd_out,
         register_we_out, data_we_out};
    return p;
  endfunction

  function automatic vec_t v(input logic rst, fl, iv, ordy, input logic [31:0] alu,
                             input logic rwe, dwe, e_ov, e_ir, input logic [31:0] e_alu,
                             input logic e_rwe, e_dwe, input logic [3:0] e_st);
    vec_t r;
    r.rst = rst; r.fl = fl; r.iv = iv; r.ordy = ordy; r.alu = alu; r.rwe = rwe; r.dwe = dwe;
    r.e_ov = e_ov; r.e_ir = e_ir; r.e_alu = e_alu; r.e_rwe = e_rwe; r.e_dwe = e_dwe;
    r.e_st = e_st;
    return r;
  endfunction

  vec_t vecs[$];
  pay_t mq[$];
  int   mcnt;

  initial begin
    // rst fl iv or  alu     rwe dwe | ov ir  alu     rwe dwe st
    vecs.push_back(v(1,0,0,0, 32'h0,  0,0,  0,1, 32'h0,  0,0, 0));
    vecs.push_back(v(0,0,1,1, 32'h1,  1,0,  1,1, 32'h1,  1,0, 0));
    vecs.push_back(v(0,0,1,1, 32'h2,  1,0,  1,1, 32'h2,  1,0, 0));
    vecs.push_back(v(0,0,1,1, 32'h3,  0,1,  1,1, 32'h3,  0,1, 0));
    vecs.push_back(v(0,0,1,1, 32'h4,  0,1,  1,1, 32'h4,  0,1, 0));
    vecs.push_back(v(0,0,0,1, 32'h0,  0,0,  0,1, 32'h0,  0,0, 0));
    vecs.push_back(v(0,0,1,0, 32'h10, 1,1,  1,1, 32'h10, 1,1, 0));
    vecs.push_back(v(0,0,1,0, 32'h20, 0,0,  1,0, 32'h10, 1,1, 1));
    vecs.push_back(v(0,0,0,0, 32'h0,  0,0,  1,0, 32'h10, 1,1, 2));
    vecs.push_back(v(0,0,0,0, 32'h0,  0,0,  1,0, 32'h10, 1,1, 3));
    vecs.push_back(v(0,0,0,1, 32'h0,  0,0,  1,1, 32'h20, 0,0, 3));
    vecs.push_back(v(0,0,0,1, 32'h0,  0,0,  0,1, 32'h0,  0,0, 3));
    vecs.push_back(v(0,0,1,0, 32'h30, 1,0,  1,1, 32'h30, 1,0, 3));
    vecs.push_back(v(0,0,1,0, 32'h40, 0,1,  1,0, 32'h30, 1,0, 4));
    vecs.push_back(v(0,1,1,0, 32'h99, 1,1,  0,1, 32'h0,  0,0, 5));
    vecs.push_back(v(0,0,0,1, 32'h0,  1,1,  0,1, 32'h0,  0,0, 5));
    vecs.push_back(v(0,0,0,0, 32'h0,  1,1,  0,1, 32'h0,  0,0, 5));
    vecs.push_back(v(0,0,1,0, 32'h55, 1,0,  1,1, 32'h55, 1,0, 5));
    vecs.push_back(v(0,0,1,0, 32'h66, 0,1,  1,0, 32'h55, 1,0, 6));
    vecs.push_back(v(1,0,1,0, 32'h77, 1,1,  0,1, 32'h0,  0,0, 0));
    vecs.push_back(v(0,0,1,1, 32'h77, 1,1,  1,1, 32'h77, 1,1, 0));
    vecs.push_back(v(0,0,0,1, 32'h0,  0,0,  0,1, 32'h0,  0,0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].fl, vecs[i].iv, vecs[i].ordy,
            mkpay(vecs[i].alu, vecs[i].rwe, vecs[i].dwe));
      step();
      chk($sformatf("vec%0d out_valid", i), 128'(out_valid), 128'(vecs[i].e_ov));
      chk($sformatf("vec%0d in_ready", i), 128'(in_ready), 128'(vecs[i].e_ir));
      chk($sformatf("vec%0d register_we_out", i), 128'(register_we_out), 128'(vecs[i].e_rwe));
      chk($sformatf("vec%0d data_we_out", i), 128'(data_we_out), 128'(vecs[i].e_dwe));
      chk($sformatf("vec%0d stall_count", i), 128'(stall_count), 128'(vecs[i].e_st));
      if (vecs[i].e_ov)
        chk($sformatf("vec%0d payload", i), 128'(dut_pay()),
            128'(mkpay(vecs[i].e_alu, vecs[i].e_rwe, vecs[i].e_dwe)));
      if (vecs[i].rst)
        chk($sformatf("vec%0d reset payload", i), 128'(dut_pay()), 128'(0));
    end

    // Stall counter saturation with output held stable under back-pressure.
    drive(1, 0, 0, 0, mkpay(32'h0, 0, 0));
    step();
    drive(0, 0, 1, 0, mkpay(32'h88, 1, 1));
    step();
    chk("sat push stall_count", 128'(stall_count), 128'(0));
    drive(0, 0, 0, 0, mkpay(32'h0, 0, 0));
    for (int k = 0; k < 20; k++) begin
      step();
      chk($sformatf("sat cyc%0d stall_count", k), 128'(stall_count),
          128'((k + 1 > 15) ? 15 : k + 1));
      chk($sformatf("sat cyc%0d held payload", k), 128'(dut_pay()),
          128'(mkpay(32'h88, 1, 1)));
    end
    drive(0, 0, 0, 1, mkpay(32'h0, 0, 0));
    step();
    chk("sat drain out_valid", 128'(out_valid), 128'(0));
    chk("sat drain stall_count", 128'(stall_count), 128'(15));
    drive(0, 1, 1, 1, mkpay(32'h5, 1, 1));
    step();
    chk("sat flush keeps stall_count", 128'(stall_count), 128'(15));
    chk("sat flush out_valid", 128'(out_valid), 128'(0));

    // Random traffic against a FIFO-of-payloads reference.
    mq.delete();
    mcnt = 0;
    for (int i = 0; i < 800; i++) begin
      logic rst, fl, iv, ordy, mov, mir;
      pay_t p;
      rst  = (i == 0) || ($urandom_range(0, 99) == 0);
      fl   = ($urandom_range(0, 24) == 0);
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ((i / 100) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      p    = pay_t'({$urandom, $urandom, $urandom, $urandom});
      mov  = (mq.size() > 0);
      mir  = (mq.size() < 2);
      drive(rst, fl, iv, ordy, p);
      step();
      if (rst) begin
        mq.delete();
        mcnt = 0;
      end else begin
        if (mov && !ordy && mcnt < 15) mcnt++;
        if (fl) begin
          mq.delete();
        end else begin
          if (mov && ordy) void'(mq.pop_front());
          if (iv && mir) mq.push_back(p);
        end
      end
      chk($sformatf("rnd%0d out_valid", i), 128'(out_valid), 128'(mq.size() > 0));
      chk($sformatf("rnd%0d in_ready", i), 128'(in_ready), 128'(mq.size() < 2));
      chk($sformatf("rnd%0d stall_count", i), 128'(stall_count), 128'(mcnt));
      if (mq.size() > 0) begin
        chk($sformatf("rnd%0d payload", i), 128'(dut_pay()), 128'(mq[0]));
      end else begin
        chk($sformatf("rnd%0d we gated", i), 128'({register_we_out, data_we_out}), 128'(0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
